// File: rtl/ns_txpkt_pkg.sv
// Shared types and helpers for the TX packet generator.
package ns_txpkt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam int LANE_W = 64;

  // Widest keep vector the helper can build; covers data widths up to 2048 bits.
  localparam int KEEP_MAX = 256;

  // One 64-bit lane of the deterministic beat pattern.
  function automatic logic [LANE_W-1:0] lane_word(input logic [31:0] seq,
                                                  input logic [15:0] beat,
                                                  input logic [15:0] lane);
    return {seq, beat, lane};
  endfunction

  // Byte enables for a beat: full unless this is the last beat of a packet
  // with a nonzero remainder, in which case only the low nbytes are set.
  function automatic logic [KEEP_MAX-1:0] keep_of_bytes(input logic [15:0] nbytes,
                                                        input logic        is_last);
    logic [KEEP_MAX-1:0] k;
    for (int i = 0; i < KEEP_MAX; i++) begin
      k[i] = !is_last || (nbytes == 16'd0) || (i < int'(nbytes));
    end
    return k;
  endfunction

endpackage

// File: rtl/ns_txpkt_gen_pattern.sv
// Combinational beat builder: data pattern and byte enables for one beat.
module ns_beat_pattern
  import ns_txpkt_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic [31:0]     seq,
  input  logic [15:0]     beat,
  input  logic [15:0]     rem_bytes,
  input  logic            is_last,
  output logic [DW-1:0]   tdata,
  output logic [DW/8-1:0] tkeep
);

  localparam int NLANE = DW / LANE_W;
  localparam int KW    = DW / 8;

  // Every lane carries the pattern, including lanes masked off by tkeep.
  always_comb begin
    tdata = '0;
    for (int k = 0; k < NLANE; k++) begin
      tdata[k*LANE_W +: LANE_W] = lane_word(seq, beat, 16'(k));
    end
    tkeep = KW'(keep_of_bytes(rem_bytes, is_last));
  end

endmodule

// File: rtl/ns_txpkt_gen.sv
// Programmable burst generator of fixed-length patterned packets for a CMAC
// TX stream, with a running count of completed packets.
//
//   state | meaning
//   IDLE  | waiting for start; stream quiet, stop ignored
//   SEND  | presenting beats; tvalid held high for the whole packet
//   GAP   | inter-packet idle, down-counting the latched gap length
module ns_txpkt_gen
  import ns_txpkt_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            start,
  input  logic            stop,
  input  logic [15:0]     packet_length,
  input  logic [31:0]     packet_count,
  input  logic [15:0]     gap_cycles,
  output logic [DW-1:0]   axis_tx_tdata,
  output logic [DW/8-1:0] axis_tx_tkeep,
  output logic            axis_tx_tlast,
  output logic            axis_tx_tvalid,
  input  logic            axis_tx_tready,
  output logic            busy,
  output logic [63:0]     packets_sent
);

  localparam int KW = DW / 8;
  localparam int RW = $clog2(KW);

  tx_state_e       state_q, state_d;
  logic [31:0]     seq_q, seq_d;
  logic [15:0]     beat_q, beat_d;
  logic [31:0]     remaining_q, remaining_d;
  logic [31:0]     count_q, count_d;
  logic [15:0]     gap_q, gap_d;
  logic [15:0]     gap_cnt_q, gap_cnt_d;
  logic [15:0]     last_idx_q, last_idx_d;
  logic [15:0]     rem_q, rem_d;
  logic            stop_flag_q, stop_flag_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic [DW-1:0]   tdata_q, tdata_d;
  logic [KW-1:0]   tkeep_q, tkeep_d;
  logic [63:0]     sent_q, sent_d;

  logic [31:0]     pat_seq;
  logic [15:0]     pat_beat;
  logic [15:0]     pat_rem;
  logic            pat_last;
  logic            load_beat;
  logic [DW-1:0]   pat_tdata;
  logic [KW-1:0]   pat_tkeep;

  logic [15:0]     start_last_idx;
  logic [15:0]     start_rem;
  logic            hs;
  logic            stop_seen;

  // Last beat index and tail byte count derived from a candidate length (len >= 1).
  always_comb begin
    start_last_idx = (packet_length - 16'd1) >> RW;
    start_rem      = 16'(packet_length[RW-1:0]);
  end

  ns_beat_pattern #(.DW(DW)) u_pattern (
    .seq       (pat_seq),
    .beat      (pat_beat),
    .rem_bytes (pat_rem),
    .is_last   (pat_last),
    .tdata     (pat_tdata),
    .tkeep     (pat_tkeep)
  );

  // Next-state logic; load_beat selects the beat the output registers take next.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    beat_d      = beat_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    last_idx_d  = last_idx_q;
    rem_d       = rem_q;
    stop_flag_d = stop_flag_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    sent_d      = sent_q;
    pat_seq     = seq_q;
    pat_beat    = beat_q;
    pat_rem     = rem_q;
    pat_last    = 1'b0;
    load_beat   = 1'b0;

    hs        = tvalid_q & axis_tx_tready;
    stop_seen = stop_flag_q | stop;

    case (state_q)
      IDLE: begin
        if (start && (packet_length != 16'd0)) begin
          count_d     = packet_count;
          gap_d       = gap_cycles;
          last_idx_d  = start_last_idx;
          rem_d       = start_rem;
          seq_d       = 32'd0;
          beat_d      = 16'd0;
          remaining_d = packet_count;
          state_d     = SEND;
          tvalid_d    = 1'b1;
          pat_seq     = 32'd0;
          pat_beat    = 16'd0;
          pat_rem     = start_rem;
          pat_last    = (start_last_idx == 16'd0);
          load_beat   = 1'b1;
        end
      end

      SEND: begin
        stop_flag_d = stop_seen;
        if (hs) begin
          if (tlast_q) begin
            sent_d = sent_q + 64'd1;
            seq_d  = seq_q + 32'd1;
            beat_d = 16'd0;
            if (count_q != 32'd0) begin
              remaining_d = remaining_q - 32'd1;
            end
            if (stop_seen || ((count_q != 32'd0) && (remaining_q == 32'd1))) begin
              state_d     = IDLE;
              tvalid_d    = 1'b0;
              tlast_d     = 1'b0;
              stop_flag_d = 1'b0;
            end else if (gap_q != 16'd0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
            end else begin
              pat_seq   = seq_q + 32'd1;
              pat_beat  = 16'd0;
              pat_last  = (last_idx_q == 16'd0);
              load_beat = 1'b1;
            end
          end else begin
            beat_d    = beat_q + 16'd1;
            pat_beat  = beat_q + 16'd1;
            pat_last  = ((beat_q + 16'd1) == last_idx_q);
            load_beat = 1'b1;
          end
        end
      end

      GAP: begin
        if (stop_seen) begin
          state_d     = IDLE;
          stop_flag_d = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
          if (gap_cnt_q == 16'd1) begin
            state_d   = SEND;
            tvalid_d  = 1'b1;
            pat_seq   = seq_q;
            pat_beat  = 16'd0;
            pat_last  = (last_idx_q == 16'd0);
            load_beat = 1'b1;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        stop_flag_d = 1'b0;
      end
    endcase

    if (load_beat) begin
      tlast_d = pat_last;
    end
  end

  // Data and keep only change when a new beat is loaded, so a stalled beat holds.
  always_comb begin
    tdata_d = load_beat ? pat_tdata : tdata_q;
    tkeep_d = load_beat ? pat_tkeep : tkeep_q;
  end

  // State and registered stream outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      beat_q      <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      last_idx_q  <= '0;
      rem_q       <= '0;
      stop_flag_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      sent_q      <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      beat_q      <= beat_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      last_idx_q  <= last_idx_d;
      rem_q       <= rem_d;
      stop_flag_q <= stop_flag_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      sent_q      <= sent_d;
    end
  end

  assign axis_tx_tdata  = tdata_q;
  assign axis_tx_tkeep  = tkeep_q;
  assign axis_tx_tlast  = tlast_q;
  assign axis_tx_tvalid = tvalid_q;
  assign busy           = (state_q != IDLE);
  assign packets_sent   = sent_q;

endmodule

// File: tb/tb_ns_txpkt_gen.sv
// Bench for ns_txpkt_gen: scoreboard of expected beats plus per-scenario checks.
module tb_ns_txpkt_gen;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   packet_length = '0;
  logic [31:0]   packet_count = '0;
  logic [15:0]   gap_cycles = '0;
  logic [DW-1:0] axis_tx_tdata;
  logic [KW-1:0] axis_tx_tkeep;
  logic          axis_tx_tlast;
  logic          axis_tx_tvalid;
  logic          axis_tx_tready = 1'b1;
  logic          busy;
  logic [63:0]   packets_sent;

  int errors = 0;
  int checks = 0;
  int tready_pct = 100;
  int hs_cnt = 0;
  logic [63:0] exp_sent = '0;

  beat_t sb[$];
  int    gaps[$];
  logic  gap_track = 1'b0;

  ns_txpkt_gen #(.DW(DW)) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .start          (start),
    .stop           (stop),
    .packet_length  (packet_length),
    .packet_count   (packet_count),
    .gap_cycles     (gap_cycles),
    .axis_tx_tdata  (axis_tx_tdata),
    .axis_tx_tkeep  (axis_tx_tkeep),
    .axis_tx_tlast  (axis_tx_tlast),
    .axis_tx_tvalid (axis_tx_tvalid),
    .axis_tx_tready (axis_tx_tready),
    .busy           (busy),
    .packets_sent   (packets_sent)
  );

  always #5 clk = ~clk;

  // Sink ready pattern, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      axis_tx_tready = ($urandom_range(0, 99) < tready_pct);
    end
  end

  // Stream monitor: scoreboard pops, hold-stability and no-drop checks, gap lengths.
  initial begin : monitor
    logic          pend;
    logic          in_pkt;
    int            idle_run;
    logic [DW-1:0] h_data;
    logic [KW-1:0] h_keep;
    logic          h_last;
    beat_t         e;
    pend = 1'b0; in_pkt = 1'b0; idle_run = 0;
    h_data = '0; h_keep = '0; h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        pend = 1'b0; in_pkt = 1'b0; idle_run = 0; gap_track = 1'b0;
      end else begin
        if (pend) begin
          checks++;
          if (axis_tx_tvalid !== 1'b1 || axis_tx_tdata !== h_data ||
              axis_tx_tkeep !== h_keep || axis_tx_tlast !== h_last) begin
            errors++;
            $display("FAIL hold_stable: got valid=%b last=%b keep=%h lane0=%h, held last=%b keep=%h lane0=%h",
                     axis_tx_tvalid, axis_tx_tlast, axis_tx_tkeep, axis_tx_tdata[63:0],
                     h_last, h_keep, h_data[63:0]);
          end
        end
        if (in_pkt) begin
          checks++;
          if (axis_tx_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL valid_mid_packet: tvalid=%b required 1", axis_tx_tvalid);
          end
        end
        if (gap_track) begin
          if (axis_tx_tvalid === 1'b1) begin
            gaps.push_back(idle_run);
            gap_track = 1'b0;
          end else begin
            idle_run++;
          end
        end
        if (axis_tx_tvalid === 1'b1 && axis_tx_tready === 1'b1) begin
          hs_cnt++;
          pend = 1'b0;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: lane0=%h last=%b, no beat expected",
                     axis_tx_tdata[63:0], axis_tx_tlast);
          end else begin
            e = sb.pop_front();
            if (axis_tx_tdata !== e.data || axis_tx_tkeep !== e.keep || axis_tx_tlast !== e.last) begin
              errors++;
              $display("FAIL beat: got lane0=%h lane7=%h keep=%h last=%b, required lane0=%h lane7=%h keep=%h last=%b",
                       axis_tx_tdata[63:0], axis_tx_tdata[511:448], axis_tx_tkeep, axis_tx_tlast,
                       e.data[63:0], e.data[511:448], e.keep, e.last);
            end
          end
          in_pkt = !axis_tx_tlast;
          if (axis_tx_tlast === 1'b1) begin
            gap_track = 1'b1;
            idle_run  = 0;
          end
        end else if (axis_tx_tvalid === 1'b1) begin
          pend = 1'b1;
          h_data = axis_tx_tdata; h_keep = axis_tx_tkeep; h_last = axis_tx_tlast;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_packet(input logic [31:0] seq, input int len);
    int nb;
    int r;
    nb = (len + KW - 1) / KW;
    r  = len % KW;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      for (int k = 0; k < DW / 64; k++) begin
        e.data[k*64 +: 64] = {seq, 16'(b), 16'(k)};
      end
      e.last = (b == nb - 1);
      e.keep = '1;
      if (e.last && r != 0) e.keep = {KW{1'b1}} >> (KW - r);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [15:0] len, input logic [31:0] cnt, input logic [15:0] gap);
    @(posedge clk); #1;
    packet_length = len; packet_count = cnt; gap_cycles = gap;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < max_cyc) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout: busy=%b after %0d cycles, required 0", name, busy, cyc);
    end
  endtask

  task automatic clear_stats();
    hs_cnt = 0;
    gaps.delete();
    gap_track = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (axis_tx_tvalid !== 1'b0 || axis_tx_tlast !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b last=%b busy=%b, required 0 0 0", axis_tx_tvalid, axis_tx_tlast, busy);
    end
    checks++;
    if (axis_tx_tdata !== '0 || axis_tx_tkeep !== '0) begin
      errors++;
      $display("FAIL reset_data: lane0=%h keep=%h, required 0", axis_tx_tdata[63:0], axis_tx_tkeep);
    end
    checks++;
    if (packets_sent !== 64'd0) begin
      errors++;
      $display("FAIL reset_sent: got %0d required 0", packets_sent);
    end
  endtask

  task automatic test_single_long();
    int cyc;
    clear_stats();
    tready_pct = 100;
    push_packet(32'd0, 4160);
    pulse_start(16'd4160, 32'd1, 16'd0);
    checks++;
    if (axis_tx_tvalid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_valid_rise: valid=%b busy=%b, required 1 1", axis_tx_tvalid, busy);
    end
    wait_idle("single", 500, cyc);
    exp_sent = exp_sent + 64'd1;
    checks++;
    if (cyc != 65) begin
      errors++;
      $display("FAIL single_busy_cycles: got %0d required 65", cyc);
    end
    checks++;
    if (hs_cnt != 65) begin
      errors++;
      $display("FAIL single_beats: got %0d required 65", hs_cnt);
    end
    checks++;
    if (packets_sent !== exp_sent) begin
      errors++;
      $display("FAIL single_sent: got %0d required %0d", packets_sent, exp_sent);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_leftover: %0d beats not seen, required 0", sb.size());
    end
  endtask

  task automatic test_gap();
    int cyc;
    clear_stats();
    tready_pct = 100;
    for (int p = 0; p < 3; p++) push_packet(32'(p), 100);
    pulse_start(16'd100, 32'd3, 16'd5);
    wait_idle("gap", 500, cyc);
    exp_sent = exp_sent + 64'd3;
    checks++;
    if (gaps.size() != 2) begin
      errors++;
      $display("FAIL gap_count: got %0d gaps required 2", gaps.size());
    end else begin
      foreach (gaps[i]) begin
        checks++;
        if (gaps[i] != 5) begin
          errors++;
          $display("FAIL gap_len[%0d]: got %0d idle cycles required 5", i, gaps[i]);
        end
      end
    end
    checks++;
    if (hs_cnt != 6) begin
      errors++;
      $display("FAIL gap_beats: got %0d required 6", hs_cnt);
    end
    checks++;
    if (packets_sent !== exp_sent) begin
      errors++;
      $display("FAIL gap_sent: got %0d required %0d", packets_sent, exp_sent);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    clear_stats();
    tready_pct = 30;
    push_packet(32'd0, 4160);
    push_packet(32'd1, 4160);
    pulse_start(16'd4160, 32'd2, 16'd0);
    wait_idle("backpressure", 5000, cyc);
    tready_pct = 100;
    exp_sent = exp_sent + 64'd2;
    checks++;
    if (hs_cnt != 130) begin
      errors++;
      $display("FAIL bp_handshakes: got %0d required 130", hs_cnt);
    end
    checks++;
    if (packets_sent !== exp_sent) begin
      errors++;
      $display("FAIL bp_sent: got %0d required %0d", packets_sent, exp_sent);
    end
  endtask

  task automatic test_stop();
    int   cyc;
    int   viol;
    logic found;
    clear_stats();
    tready_pct = 100;
    repeat (2) @(posedge clk);
    for (int p = 0; p < 8; p++) push_packet(32'(p), 64);
    pulse_start(16'd64, 32'd0, 16'd0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (axis_tx_tvalid === 1'b1 && axis_tx_tdata[63:32] === 32'd7) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stop_pkt7_seen: packet 7 not presented within 200 cycles");
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_idle("stop", 200, cyc);
    exp_sent = exp_sent + 64'd8;
    checks++;
    if (packets_sent !== exp_sent) begin
      errors++;
      $display("FAIL stop_sent: got %0d required %0d", packets_sent, exp_sent);
    end
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (axis_tx_tvalid !== 1'b0) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL stop_quiet: tvalid high in %0d cycles after stop, required 0", viol);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stop_leftover: %0d beats not seen, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_stats();
    tready_pct = 100;
    push_packet(32'd0, 4160);
    pulse_start(16'd4160, 32'd1, 16'd0);
    cyc = 0;
    while (hs_cnt < 30 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    aresetn = 1'b0;
    #1;
    checks++;
    if (axis_tx_tvalid !== 1'b0 || packets_sent !== 64'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: valid=%b sent=%0d busy=%b, required 0 0 0", axis_tx_tvalid, packets_sent, busy);
    end
    @(negedge clk);
    sb.delete();
    exp_sent = '0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    checks++;
    if (axis_tx_tvalid !== 1'b0 || packets_sent !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid_release: valid=%b sent=%0d, required 0 0", axis_tx_tvalid, packets_sent);
    end
    clear_stats();
    push_packet(32'd0, 4160);
    pulse_start(16'd4160, 32'd1, 16'd0);
    wait_idle("rst_resume", 500, cyc);
    exp_sent = exp_sent + 64'd1;
    checks++;
    if (hs_cnt != 65 || packets_sent !== exp_sent) begin
      errors++;
      $display("FAIL rst_resume: beats=%0d sent=%0d, required 65 %0d", hs_cnt, packets_sent, exp_sent);
    end
  endtask

  task automatic test_ignored_starts();
    int cyc;
    clear_stats();
    tready_pct = 100;
    pulse_start(16'd0, 32'd4, 16'd0);
    checks++;
    if (busy !== 1'b0 || axis_tx_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL len0_start: busy=%b valid=%b, required 0 0", busy, axis_tx_tvalid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_later: busy=%b required 0", busy);
    end
    for (int p = 0; p < 3; p++) push_packet(32'(p), 64);
    pulse_start(16'd64, 32'd3, 16'd2);
    @(posedge clk); #1;
    packet_length = 16'd4160; packet_count = 32'd10; gap_cycles = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("busy_start", 300, cyc);
    exp_sent = exp_sent + 64'd3;
    checks++;
    if (hs_cnt != 3) begin
      errors++;
      $display("FAIL busy_start_beats: got %0d required 3", hs_cnt);
    end
    checks++;
    if (packets_sent !== exp_sent) begin
      errors++;
      $display("FAIL busy_start_sent: got %0d required %0d", packets_sent, exp_sent);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    aresetn = 1'b1;
    test_single_long();
    test_gap();
    test_backpressure();
    test_stop();
    test_reset_mid();
    test_ignored_starts();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ns_txpkt_gen.md
Name: ns_txpkt_gen

Overview:
Generates a programmable burst of fixed-length packets on the "axis_tx" input of a CMAC. Its purpose is to produce traffic that the RX-side packet counters can classify, for example 4160-byte packets (4096-byte payload plus 64-byte header). Each beat carries a deterministic pattern so far-end checkers can verify it. The block also counts the packets it has sent.

Parameters:
DW, 512, AXI-stream data width in bits; must be a multiple of 64.

Ports:
clk  in  1  sole clock.
aresetn  in  1  asynchronous, active-low reset; all flops reset immediately on assertion.
start  in  1  one-cycle pulse; begins a burst when idle.
stop  in  1  level or pulse; ends a burst at the next packet boundary.
packet_length  in  16  bytes per packet; sampled on accepted start.
packet_count  in  32  packets per burst, 0 = continuous; sampled on accepted start.
gap_cycles  in  16  idle cycles between packets; sampled on accepted start.
axis_tx_tdata  out  DW  packet data.
axis_tx_tkeep  out  DW/8  byte enables, low-order contiguous.
axis_tx_tlast  out  1  last beat of packet.
axis_tx_tvalid  out  1  beat valid.
axis_tx_tready  in  1  sink ready.
busy  out  1  high in any non-IDLE state.
packets_sent  out  64  packets completed since reset.

Behaviour:
- Reset values: tvalid, tlast and busy = 0; tdata, tkeep and packets_sent = 0; FSM in IDLE; seq, beat and remaining = 0.
- Beat math: BPB = DW/8. beats = ceil(len/BPB).
- Partial final beat: tkeep has the low (len mod BPB) bits set; if len mod BPB = 0, tkeep is all ones.
- Full beats: tkeep all ones.
- Pattern: 64-bit lane k of beat b in packet seq = {seq[31:0], b[15:0], k[15:0]}. The pattern is also present in masked lanes.
- FSM IDLE:
  - start=1 with packet_length≠0: latch the inputs; seq←0; beat←0; remaining←packet_count; go to SEND.
  - start with packet_length=0: ignored.
  - tvalid rises the cycle after start is accepted.
- FSM SEND:
  - tvalid=1; tlast=1 only on beat beats-1.
  - Handshake = tvalid & tready. On a handshake, beat increments.
  - On the tlast handshake:
    - packets_sent++; seq++; beat←0; remaining decrements when count≠0.
    - Go to IDLE if stop has been seen or if count≠0 and remaining reaches 0.
    - Else go to GAP if gap≠0, else stay in SEND (back-to-back packets, no bubble).
- FSM GAP: tvalid=0 for exactly gap_cycles cycles, then SEND. A stop seen during GAP goes to IDLE at the next cycle.
- AXI rule: once tvalid=1, tdata, tkeep and tlast are held stable until the handshake. tvalid never drops mid-packet.
- Registered outputs: all stream outputs come from flops, so tready may fall or rise in any cycle without a combinational path.
- stop:
  - Latched into a sticky flag while busy.
  - Never truncates a packet; the packet in flight completes with tlast.
  - The flag clears on entering IDLE.
  - stop while IDLE has no effect.
- start while busy: ignored. Input changes while busy: ignored (only the latched copies are used).
- Simultaneous start and stop in IDLE: start is accepted, stop is ignored.
- packets_sent: wraps modulo 2^64 and is cleared only by aresetn; seq wraps modulo 2^32.
- aresetn mid-packet: outputs drop to their reset values immediately. The truncated packet is not counted. No automatic resume.

Decomposition:
- Package ns_txpkt_pkg contains:
  - FSM state enum: IDLE, SEND, GAP.
  - Function for tkeep of a given byte count.
  - Function for lane-pattern construction.
- Sub-module ns_beat_pattern: combinational. Inputs seq, beat, byte-remainder and is_last. Outputs tdata and tkeep, which the top-level registers.

Test Plan:
1. DW=512, len=4160, count=1, gap=0, tready=1 → 65 beats (0x41), all tkeep=0xFFFF_FFFF_FFFF_FFFF, tlast on beat 64, packets_sent=1, busy falls after the tlast handshake.
2. len=100, count=3, gap=5 → each packet is 2 beats, second beat tkeep=0x0000_000F_FFFF_FFFF. Exactly 5 tvalid=0 cycles between packets. Lane 0 of packet 2 beat 1 = 0x0000_0002_0001_0000. packets_sent=3.
3. len=4160, count=2, random tready at 30% → tdata, tkeep and tlast stay stable whenever tvalid & !tready. Exactly 130 handshakes.
4. count=0 (continuous), len=64, gap=0; assert stop during packet 7 beat 0 → packet 7 completes, packets_sent=8, busy=0, no further tvalid.
5. aresetn low during beat 30 of a 4160-byte packet → next cycle tvalid=0, packets_sent=0. After release, a new start sends a full packet with seq=0.
6. start with len=0 → busy stays 0. start pulsed while busy → ignored; the burst length is unchanged.
